mem_req_arbiter: RTL and testbench

//  Parametrised N-channel successor of the single arbiter<->controller link. Arbitrates NUM_CH

---
 rtl/mem_req_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that funnels NUM_CH requester channels onto a single
// memory-controller port, one outstanding op at a time. When the controller
// reports a miss, the arbiter issues a fill to the next level, waits for it,
// pulses repair_resolved and reissues the op. An op that is still missing after
// MAX_RETRY repairs completes with ch_resp_err set.
module mem_req_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MAX_RETRY = 3,
  localparam int MASK_W   = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req_valid,
  input  logic [NUM_CH-1:0]          ch_req_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_req_wdata,
  input  logic [NUM_CH*MASK_W-1:0]   ch_req_wmask,
  output logic [NUM_CH-1:0]          ch_req_ready,
  output logic [NUM_CH-1:0]          ch_resp_valid,
  output logic [DATA_W-1:0]          ch_resp_rdata,
  output logic                       ch_resp_err,
  output logic                       raddr_valid,
  output logic [ADDR_W-1:0]          raddr,
  output logic                       waddr_valid,
  output logic [ADDR_W-1:0]          waddr,
  output logic [DATA_W-1:0]          wdata,
  output logic [MASK_W-1:0]          wmask,
  input  logic                       mem_ready,
  input  logic                       rdata_valid,
  input  logic [DATA_W-1:0]          rdata,
  input  logic                       read_miss_repair,
  input  logic                       write_miss_repair,
  input  logic [ADDR_W-1:0]          missed_addr,
  output logic                       fill_req_valid,
  output logic [ADDR_W-1:0]          fill_addr,
  input  logic                       fill_done,
  output logic                       repair_resolved,
  output logic                       proto_err
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FILL,
    S_FILL_WAIT,
    S_RESOLVE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CH_W-1:0]     rr_ptr;
  logic [2:0]          retry;

  // Search helpers for the round-robin pick
  logic [CH_W:0]       rr_sum;
  logic [CH_W-1:0]     rr_idx;
  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;
  logic [NUM_CH-1:0]   grant_oh;

  // Latched op payload (data only, no reset needed)
  logic [CH_W-1:0]     grant_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [ADDR_W-1:0]   miss_addr_q;
  logic [NUM_CH-1:0]   resp_oh;

  logic                do_grant;
  logic                retry_inc;
  logic                done_ok;
  logic                done_err;
  logic                miss_both;
  logic                miss_hit;
  logic                miss_wrong;
  logic                proto_viol;

  // First valid channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    rr_idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      end
      rr_idx = rr_sum[CH_W-1:0];
      if (!grant_found && ch_req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  assign grant_oh = NUM_CH'(1) << grant_idx;
  assign resp_oh  = NUM_CH'(1) << grant_q;

  // A miss only counts when it matches the op type; both flags at once is
  // treated as garbage and ignored entirely.
  assign miss_both  = read_miss_repair & write_miss_repair;
  assign miss_hit   = (state == S_WAIT) & ~miss_both &
                      (we_q ? write_miss_repair : read_miss_repair);
  assign miss_wrong = (state == S_WAIT) & ~miss_both &
                      (we_q ? read_miss_repair : write_miss_repair);
  assign proto_viol = miss_wrong
                    | ((state == S_WAIT) & miss_both)
                    | ((state != S_WAIT) & (read_miss_repair | write_miss_repair | rdata_valid))
                    | ((state != S_FILL_WAIT) & fill_done);

  // Next-state and per-cycle action decode.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    retry_inc = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_found) begin
          do_grant  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A miss in the same cycle as rdata_valid wins; that data is dropped.
        if (miss_hit) begin
          if (retry == 3'(MAX_RETRY)) begin
            done_err  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            retry_inc = 1'b1;
            state_nxt = S_FILL;
          end
        end else if (rdata_valid) begin
          done_ok   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_FILL:      state_nxt = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (fill_done) state_nxt = S_RESOLVE;
      end
      S_RESOLVE:   state_nxt = S_ISSUE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Control state, round-robin pointer, retry count and registered responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      retry         <= '0;
      ch_resp_valid <= '0;
      ch_resp_err   <= 1'b0;
      ch_resp_rdata <= '0;
      proto_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        retry  <= '0;
      end else if (retry_inc) begin
        retry <= retry + 3'd1;
      end
      ch_resp_valid <= (done_ok | done_err) ? resp_oh : '0;
      ch_resp_err   <= done_err;
      ch_resp_rdata <= (done_ok & ~we_q) ? rdata : '0;
      if (proto_viol) proto_err <= 1'b1;
    end
  end

  // Capture the granted request and the address of an accepted miss.
  always_ff @(posedge clk) begin
    if (do_grant) begin
      grant_q <= grant_idx;
      we_q    <= ch_req_we[grant_idx];
      addr_q  <= ch_req_addr[grant_idx*ADDR_W +: ADDR_W];
      wdata_q <= ch_req_wdata[grant_idx*DATA_W +: DATA_W];
      wmask_q <= ch_req_wmask[grant_idx*MASK_W +: MASK_W];
    end
    if (miss_hit) miss_addr_q <= missed_addr;
  end

  // Payload outputs are forced to zero whenever their qualifier is low.
  assign ch_req_ready    = (state == S_IDLE && grant_found && !rst) ? grant_oh : '0;
  assign raddr_valid     = (state == S_ISSUE) & ~we_q;
  assign waddr_valid     = (state == S_ISSUE) & we_q;
  assign raddr           = raddr_valid ? addr_q  : '0;
  assign waddr           = waddr_valid ? addr_q  : '0;
  assign wdata           = waddr_valid ? wdata_q : '0;
  assign wmask           = waddr_valid ? wmask_q : '0;
  assign fill_req_valid  = (state == S_FILL);
  assign fill_addr       = fill_req_valid ? miss_addr_q : '0;
  assign repair_resolved = (state == S_RESOLVE);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Randomized bench for mem_req_arbiter: the bench plays both the requesters and
// the memory controller, and predicts grants and responses from a plain
// round-robin / retry-count model of the intended behaviour.
module tb_mem_req_arbiter;

  localparam int NUM_CH    = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 128;
  localparam int MAX_RETRY = 3;
  localparam int MASK_W    = DATA_W / 8;
  localparam int CW        = 128;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH-1:0]        ch_req_we;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH*DATA_W-1:0] ch_req_wdata;
  logic [NUM_CH*MASK_W-1:0] ch_req_wmask;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [DATA_W-1:0]        ch_resp_rdata;
  logic                     ch_resp_err;
  logic                     raddr_valid;
  logic [ADDR_W-1:0]        raddr;
  logic                     waddr_valid;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [MASK_W-1:0]        wmask;
  logic                     mem_ready;
  logic                     rdata_valid;
  logic [DATA_W-1:0]        rdata;
  logic                     read_miss_repair;
  logic                     write_miss_repair;
  logic [ADDR_W-1:0]        missed_addr;
  logic                     fill_req_valid;
  logic [ADDR_W-1:0]        fill_addr;
  logic                     fill_done;
  logic                     repair_resolved;
  logic                     proto_err;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req_valid(ch_req_valid), .ch_req_we(ch_req_we), .ch_req_addr(ch_req_addr),
    .ch_req_wdata(ch_req_wdata), .ch_req_wmask(ch_req_wmask), .ch_req_ready(ch_req_ready),
    .ch_resp_valid(ch_resp_valid), .ch_resp_rdata(ch_resp_rdata), .ch_resp_err(ch_resp_err),
    .raddr_valid(raddr_valid), .raddr(raddr), .waddr_valid(waddr_valid), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .mem_ready(mem_ready),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .read_miss_repair(read_miss_repair), .write_miss_repair(write_miss_repair),
    .missed_addr(missed_addr), .fill_req_valid(fill_req_valid), .fill_addr(fill_addr),
    .fill_done(fill_done), .repair_resolved(repair_resolved), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_passed = 0;

  // Requester-side model: one pending request per channel
  logic              pend      [NUM_CH];
  logic              req_we    [NUM_CH];
  logic [ADDR_W-1:0] req_addr  [NUM_CH];
  logic [DATA_W-1:0] req_wdata [NUM_CH];
  logic [MASK_W-1:0] req_wmask [NUM_CH];
  int                rr;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Round-robin rule: first pending channel at or after rr, wrapping.
  function automatic int pick();
    int c;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (rr + i) % NUM_CH;
      if (pend[c]) return c;
    end
    return 0;
  endfunction

  task automatic new_req(input int c);
    pend[c]      = 1'b1;
    req_we[c]    = 1'($urandom % 2);
    req_addr[c]  = $urandom;
    req_wdata[c] = rand128();
    req_wmask[c] = MASK_W'($urandom);
  endtask

  task automatic drive_reqs();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_req_valid[c]                  = pend[c];
      ch_req_we[c]                     = req_we[c];
      ch_req_addr[c*ADDR_W +: ADDR_W]  = req_addr[c];
      ch_req_wdata[c*DATA_W +: DATA_W] = req_wdata[c];
      ch_req_wmask[c*MASK_W +: MASK_W] = req_wmask[c];
    end
  endtask

  // Inputs change 1 ns after the rising edge; single-cycle pulses drop here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_ready         = 1'b0;
    rdata_valid       = 1'b0;
    read_miss_repair  = 1'b0;
    write_miss_repair = 1'b0;
    fill_done         = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, CW'({ch_req_ready, ch_resp_valid, ch_resp_err, raddr_valid,
                            waddr_valid, fill_req_valid, repair_resolved, proto_err}), CW'(0));
    chk({tag, "_addr"}, CW'({raddr, waddr, fill_addr}), CW'(0));
    chk({tag, "_rdata"}, ch_resp_rdata, CW'(0));
    chk({tag, "_wdata"}, wdata, CW'(0));
    chk({tag, "_wmask"}, CW'(wmask), CW'(0));
  endtask

  // One complete op, starting in a cycle where the arbiter is idle.
  task automatic run_txn(input bit all_busy);
    int                g;
    int                k;
    int                d;
    int                planned;
    int                misses;
    bit                any;
    logic              t_we;
    logic [ADDR_W-1:0] t_addr;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] t_wdata;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] t_wmask;
    logic [NUM_CH-1:0] exp_oh;

    any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!pend[c] && (all_busy || ($urandom % 2 == 0))) new_req(c);
      if (pend[c]) any = 1'b1;
    end
    if (!any) new_req(int'($urandom % NUM_CH));
    drive_reqs();
    g      = pick();
    exp_oh = NUM_CH'(1) << g;
    settle();
    chk("grant", CW'(ch_req_ready), CW'(exp_oh));
    rr      = (g + 1) % NUM_CH;
    t_we    = req_we[g];
    t_addr  = req_addr[g];
    t_wdata = req_wdata[g];
    t_wmask = req_wmask[g];
    pend[g] = 1'b0;

    case ($urandom % 8)
      0, 1, 2, 3: planned = 0;
      4:          planned = 1;
      5:          planned = 2;
      6:          planned = MAX_RETRY;
      default:    planned = MAX_RETRY + 1;
    endcase
    misses = 0;

    for (int att = 0; att <= MAX_RETRY + 1; att++) begin
      k = $urandom % 6;
      for (int j = 0; j <= k; j++) begin
        next_cycle();
        if (att == 0 && j == 0) drive_reqs();
        mem_ready = (j == k);
        settle();
        chk("issue_valid", CW'({raddr_valid, waddr_valid}), CW'({~t_we, t_we}));
        if (t_we) begin
          chk("waddr", CW'(waddr), CW'(t_addr));
          chk("wdata", wdata, t_wdata);
          chk("wmask", CW'(wmask), CW'(t_wmask));
        end else begin
          chk("raddr", CW'(raddr), CW'(t_addr));
        end
      end
      d = $urandom % 4;
      for (int j = 0; j < d; j++) begin
        next_cycle();
        settle();
        chk("resp_early", CW'(ch_resp_valid), CW'(0));
      end
      next_cycle();
      if (misses < planned) begin
        maddr       = $urandom;
        missed_addr = maddr;
        if (t_we) write_miss_repair = 1'b1;
        else      read_miss_repair  = 1'b1;
        if ($urandom % 4 == 0) begin
          rdata_valid = 1'b1;
          rdata       = rand128();
        end
        misses++;
        if (misses > MAX_RETRY) begin
          next_cycle();
          settle();
          chk("err_resp", CW'({ch_resp_valid, ch_resp_err}), CW'({exp_oh, 1'b1}));
          chk("err_rdata", ch_resp_rdata, CW'(0));
          return;
        end
        next_cycle();
        settle();
        chk("fill_req", CW'({fill_req_valid, fill_addr}), CW'({1'b1, maddr}));
        chk("no_resp_on_miss", CW'(ch_resp_valid), CW'(0));
        d = $urandom % 4;
        for (int j = 0; j < d; j++) begin
          next_cycle();
          settle();
          chk("fill_wait", CW'({fill_req_valid, repair_resolved}), CW'(0));
        end
        next_cycle();
        fill_done = 1'b1;
        settle();
        chk("resolve_early", CW'(repair_resolved), CW'(0));
        next_cycle();
        settle();
        chk("repair_resolved", CW'(repair_resolved), CW'(1));
      end else begin
        data        = rand128();
        rdata_valid = 1'b1;
        rdata       = data;
        next_cycle();
        settle();
        chk("resp", CW'({ch_resp_valid, ch_resp_err}), CW'({exp_oh, 1'b0}));
        chk("resp_rdata", ch_resp_rdata, t_we ? CW'(0) : data);
        return;
      end
    end
  endtask

  initial begin
    int g;
    rst               = 1'b1;
    ch_req_valid      = '0;
    ch_req_we         = '0;
    ch_req_addr       = '0;
    ch_req_wdata      = '0;
    ch_req_wmask      = '0;
    mem_ready         = 1'b0;
    rdata_valid       = 1'b0;
    rdata             = '0;
    read_miss_repair  = 1'b0;
    write_miss_repair = 1'b0;
    missed_addr       = '0;
    fill_done         = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      pend[c]      = 1'b0;
      req_we[c]    = 1'b0;
      req_addr[c]  = '0;
      req_wdata[c] = '0;
      req_wmask[c] = '0;
    end
    rr = 0;

    @(posedge clk);
    #1;
    check_zero("reset");
    next_cycle();
    rst = 1'b0;

    // fill_done while idle is a protocol error; only rst clears it
    fill_done = 1'b1;
    settle();
    next_cycle();
    settle();
    chk("proto_fill_done_idle", CW'(proto_err), CW'(1));
    rst = 1'b1;
    settle();
    chk("proto_cleared_by_rst", CW'(proto_err), CW'(0));
    next_cycle();
    rst = 1'b0;

    for (int t = 0; t < 200; t++) run_txn(t >= 40 && t < 60);

    // Withdraw leftover requests before the idle arbiter can grant one
    for (int c = 0; c < NUM_CH; c++) pend[c] = 1'b0;
    drive_reqs();
    settle();
    chk("proto_clean", CW'(proto_err), CW'(0));

    // Read on ch1, wrong-type miss, real miss, then reset while waiting on the fill
    next_cycle();
    new_req(1);
    req_we[1] = 1'b0;
    drive_reqs();
    g = pick();
    settle();
    chk("dir_grant", CW'(ch_req_ready), CW'(NUM_CH'(1) << g));
    rr      = (g + 1) % NUM_CH;
    pend[1] = 1'b0;
    next_cycle();
    drive_reqs();
    mem_ready = 1'b1;
    settle();
    next_cycle();
    write_miss_repair = 1'b1;
    missed_addr       = 32'h0000_3000;
    settle();
    next_cycle();
    read_miss_repair = 1'b1;
    missed_addr      = 32'h0000_2000;
    settle();
    chk("proto_wrong_type", CW'(proto_err), CW'(1));
    chk("wrong_type_ignored", CW'(fill_req_valid), CW'(0));
    next_cycle();
    settle();
    chk("dir_fill", CW'({fill_req_valid, fill_addr}), CW'({1'b1, 32'h0000_2000}));
    next_cycle();
    rst = 1'b1;
    settle();
    check_zero("mid_op_rst");
    next_cycle();
    settle();
    rst = 1'b0;
    rr  = 0;
    new_req(2);
    drive_reqs();
    settle();
    chk("regrant_after_rst", CW'(ch_req_ready), CW'(4'b0100));
    chk("no_resp_after_rst", CW'(ch_resp_valid), CW'(0));

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
